noc_input_port: RTL

Per-input-port front end of a YaNoC router. It buffers incoming flits in a small FIFO and computes an XY route from each head flit. It then raises a single request line toward the matching output-port arbiter, holds it for the whole packet, and streams the granted packet's flits onto the crossbar. It sits directly upstream of the five 5-request output arbiters; one instance exists per router input.

---
 rtl/noc_input_port.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/noc_input_port.sv
`default_nettype none
// ============================================================================
// noc_input_port: input FIFO, XY route and per-packet req/grant FSM for one router input
// Revision: 1.0
// ============================================================================
module noc_input_port #(
  parameter logic [3:0] CUR_X = 4'd0,
  parameter logic [3:0] CUR_Y = 4'd0,
  parameter int         DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_flit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        req0,
  output logic        req1,
  output logic        req2,
  output logic        req3,
  output logic        req4,
  input  logic        gnt0,
  input  logic        gnt1,
  input  logic        gnt2,
  input  logic        gnt3,
  input  logic        gnt4,
  output logic [31:0] out_flit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_drop
);

  localparam int              C_AW      = $clog2(DEPTH);
  localparam int              C_CW      = C_AW + 1;
  localparam logic [C_CW-1:0] C_DEPTH   = C_CW'(DEPTH);
  localparam logic [C_CW-1:0] C_CNT_ONE = C_CW'(1);
  localparam logic [C_AW-1:0] C_PTR_ONE = C_AW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    SEND     = 2'd2
  } state_t;

  logic [31:0]     mem_q [DEPTH];
  logic [C_AW-1:0] wr_ptr_q;
  logic [C_AW-1:0] rd_ptr_q;
  logic [C_CW-1:0] count_q;
  state_t          state_q;
  state_t          state_d;
  logic [2:0]      route_q;
  logic [2:0]      route_d;
  logic [4:0]      req_q;
  logic [4:0]      req_d;
  logic            err_drop_q;

  logic [4:0]      gnt;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;
  logic            xfer;
  logic            gnt_sel;
  logic [31:0]     head;
  logic [3:0]      head_dx;
  logic [3:0]      head_dy;
  logic [2:0]      head_route;

  function automatic logic [4:0] onehot5(input logic [2:0] r);
    onehot5 = 5'b00001 << r;
  endfunction

  assign gnt      = {gnt4, gnt3, gnt2, gnt1, gnt0};
  assign empty    = (count_q == '0);
  assign full     = (count_q == C_DEPTH);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign pop      = xfer || drop;
  assign head     = mem_q[rd_ptr_q];
  assign head_dx  = head[7:4];
  assign head_dy  = head[3:0];
  assign out_flit = head;
  // Only the grant of the latched route matters; other arbiters' grants are ignored.
  assign gnt_sel  = |(gnt & onehot5(route_q));

  always_comb begin
    head_route = 3'd0;
    if (head_dx > CUR_X) begin
      head_route = 3'd2;
    end else if (head_dx < CUR_X) begin
      head_route = 3'd4;
    end else if (head_dy > CUR_Y) begin
      head_route = 3'd1;
    end else if (head_dy < CUR_Y) begin
      head_route = 3'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    req_d     = req_q;
    drop      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_d = 5'b00000;
        if (!empty) begin
          // bit 30 marks a head (types 01 and 11); anything else here is a stray flit
          if (head[30]) begin
            route_d = head_route;
            req_d   = onehot5(head_route);
            state_d = WAIT_GNT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        if (gnt_sel) begin
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = !empty && gnt_sel;
        if (out_valid && out_ready && head[31]) begin
          state_d = IDLE;
          req_d   = 5'b00000;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 5'b00000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      route_q    <= 3'd0;
      req_q      <= 5'b00000;
      err_drop_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      req_q      <= req_d;
      err_drop_q <= drop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + C_CNT_ONE;
        2'b01:   count_q <= count_q - C_CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_flit;
    end
  end

  assign req0     = req_q[0];
  assign req1     = req_q[1];
  assign req2     = req_q[2];
  assign req3     = req_q[3];
  assign req4     = req_q[4];
  assign err_drop = err_drop_q;

endmodule
`default_nettype wire
